// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg
//   Shared definitions for the RO-PUF datapath.
//   RO_CNT_WIDTH : default width of the ring-oscillator edge counters.
//   ro_count_t   : count word of that width, used by downstream comparators.
package ro_puf_pkg;

    localparam int RO_CNT_WIDTH = 32;

    typedef logic [RO_CNT_WIDTH-1:0] ro_count_t;

endpackage : ro_puf_pkg

// File: rtl/ro_edge_counter_sva.sv
// ro_edge_counter_sva
//   Assertion checker for ro_edge_counter, instantiated alongside the counter
//   with the same port connections.
//   - q holds across an edge sampled with en=0
//   - q steps by exactly one across an edge sampled with en=1
//   - q is zero while reset is high
//   A shadow copy of the previous edge's q/en is kept; it is cleared by the
//   asynchronous reset so a short reset pulse between edges does not look
//   like a bad step.
//
// Ports
//   clk, reset, en, q : same nets as the counter under check
module ro_edge_counter_sva #(
    parameter int SIZE = 32
) (
    input logic            clk,
    input logic            reset,
    input logic            en,
    input logic [SIZE-1:0] q
);

    logic            prev_valid_q;
    logic            prev_en_q;
    logic [SIZE-1:0] prev_q_q;

    // Shadow of the count and enable as they were at the previous edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid_q <= 1'b0;
            prev_en_q    <= 1'b0;
            prev_q_q     <= {SIZE{1'b0}};
        end else begin
            prev_valid_q <= 1'b1;
            prev_en_q    <= en;
            prev_q_q     <= q;
        end
    end

    a_hold_when_disabled : assert property (
        @(posedge clk) disable iff (reset)
        (prev_valid_q && !prev_en_q) |-> (q == prev_q_q));

    a_step_when_enabled : assert property (
        @(posedge clk) disable iff (reset)
        (prev_valid_q && prev_en_q) |-> (q == (prev_q_q + {{(SIZE-1){1'b0}}, 1'b1})));

    a_zero_in_reset : assert property (
        @(posedge clk) reset |-> (q == {SIZE{1'b0}}));

endmodule : ro_edge_counter_sva

// File: rtl/ro_edge_counter.sv
// ro_edge_counter
//   Binary up-counter that counts rising edges of clk while en is high.
//   clk is either a ring-oscillator output or the system clock. After en is
//   dropped the count holds so comparators can read it at leisure.
//
// Ports
//   clk   : counting clock; all state changes on its rising edge
//   reset : asynchronous, active-high; clears q and ovf immediately
//   en    : count enable, sampled on the rising edge of clk
//   q     : current count, straight from the count register
//   ovf   : sticky flag, set when q wraps from all-ones to zero
//
// Parameter
//   SIZE  : counter width in bits, legal range 2..64
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int SIZE = RO_CNT_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic [SIZE-1:0] q,
    output logic            ovf
);

    logic [SIZE-1:0] q_q;
    logic [SIZE-1:0] q_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            carry_s;

    // Next-state: increment when enabled; the MSB carry only feeds the wrap flag.
    always_comb begin
        q_d     = q_q;
        ovf_d   = ovf_q;
        carry_s = 1'b0;
        if (en) begin
            {carry_s, q_d} = {1'b0, q_q} + {{SIZE{1'b0}}, 1'b1};
            ovf_d          = ovf_q | carry_s;
        end else begin
            q_d   = q_q;
            ovf_d = ovf_q;
        end
    end

    // Count and flag registers; reset deassertion is deliberately not
    // synchronised because clk may be a free-running ring oscillator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= {SIZE{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs come straight from the registers: no path from en to q.
    assign q   = q_q;
    assign ovf = ovf_q;

endmodule : ro_edge_counter

// File: tb/tb_ro_edge_counter.sv
// tb_ro_edge_counter
//   Directed bench for ro_edge_counter: a 32-bit instance for reset, counting,
//   gating and random enable toggling, and a 4-bit instance for wrap, async
//   reset mid-count and reset dominance. Outputs are sampled away from the
//   rising edge.
module tb_ro_edge_counter;

    logic        clk;
    logic        rst32;
    logic        en32;
    logic [31:0] q32;
    logic        ovf32;
    logic        rst4;
    logic        en4;
    logic [3:0]  q4;
    logic        ovf4;

    int n_checks;
    int n_fail;
    int model_cnt;

    ro_edge_counter #(.SIZE(32)) u_dut32 (
        .clk   (clk),
        .reset (rst32),
        .en    (en32),
        .q     (q32),
        .ovf   (ovf32)
    );

    ro_edge_counter #(.SIZE(4)) u_dut4 (
        .clk   (clk),
        .reset (rst4),
        .en    (en4),
        .q     (q4),
        .ovf   (ovf4)
    );

    ro_edge_counter_sva #(.SIZE(32)) u_sva32 (
        .clk   (clk),
        .reset (rst32),
        .en    (en32),
        .q     (q32)
    );

    ro_edge_counter_sva #(.SIZE(4)) u_sva4 (
        .clk   (clk),
        .reset (rst4),
        .en    (en4),
        .q     (q4)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_cnt = 0;
        rst32 = 1'b1;
        en32  = 1'b0;
        rst4  = 1'b1;
        en4   = 1'b0;

        // Reset state
        #8;
        check_eq("reset_q32",   64'(q32),   64'd0);
        check_eq("reset_ovf32", 64'(ovf32), 64'd0);
        check_eq("reset_q4",    64'(q4),    64'd0);
        check_eq("reset_ovf4",  64'(ovf4),  64'd0);

        // Reset then count: release at 10 ns, 10 enabled edges (15..105 ns)
        #2;
        rst32 = 1'b0;
        en32  = 1'b1;
        #100;
        check_eq("count10_q", 64'(q32), 64'd10);
        en32 = 1'b0;
        #20;
        check_eq("count10_hold_q",   64'(q32),   64'd10);
        check_eq("count10_hold_ovf", 64'(ovf32), 64'd0);

        // Resynchronise to a falling edge; en is low so the extra edge is inert
        @(negedge clk);

        // Enable gating: bring q to 5, hold 8 edges, then 3 more enabled edges
        rst32 = 1'b1;
        #1;
        rst32 = 1'b0;
        en32  = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("gate_pre_q", 64'(q32), 64'd5);
        en32 = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("gate_hold_q", 64'(q32), 64'd5);
        en32 = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("gate_resume_q", 64'(q32), 64'd8);
        en32 = 1'b0;

        // Wrap on the 4-bit instance
        rst4 = 1'b0;
        en4  = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("wrap_pre_q",   64'(q4),   64'd15);
        check_eq("wrap_pre_ovf", 64'(ovf4), 64'd0);
        @(negedge clk);
        check_eq("wrap_q",   64'(q4),   64'd0);
        check_eq("wrap_ovf", 64'(ovf4), 64'd1);
        repeat (2) @(negedge clk);
        check_eq("wrap_post_q",   64'(q4),   64'd2);
        check_eq("wrap_post_ovf", 64'(ovf4), 64'd1);

        // Asynchronous reset mid-count at q=7, 3 ns pulse between edges
        repeat (5) @(negedge clk);
        check_eq("async_pre_q", 64'(q4), 64'd7);
        #1;
        rst4 = 1'b1;
        #1;
        check_eq("async_q",   64'(q4),   64'd0);
        check_eq("async_ovf", 64'(ovf4), 64'd0);
        #2;
        rst4 = 1'b0;
        @(negedge clk);
        check_eq("async_resume_q",   64'(q4),   64'd1);
        check_eq("async_resume_ovf", 64'(ovf4), 64'd0);

        // Reset dominance: reset and en both high for 5 edges
        rst4 = 1'b1;
        en4  = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("dominance_q",   64'(q4),   64'd0);
        check_eq("dominance_ovf", 64'(ovf4), 64'd0);
        en4 = 1'b0;

        // Random enable over 1000 edges against a reference count
        rst32 = 1'b1;
        #1;
        rst32 = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            en32 = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            if (en32) model_cnt++;
            @(negedge clk);
        end
        en32 = 1'b0;
        check_eq("random_q",   64'(q32),   64'(model_cnt));
        check_eq("random_ovf", 64'(ovf32), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ro_edge_counter

// File: doc/ro_edge_counter.md
Name: ro_edge_counter

Overview:
- Parameterised binary up-counter with synchronous count enable and asynchronous active-high reset.
- In the RO-PUF datapath it counts rising edges of its clock input, which is driven by a ring-oscillator output or the system clock, over a gated measurement window set by `en`.
- Downstream comparators read `q` once `en` is deasserted; `q` then holds its value indefinitely.

Parameters:
- SIZE, 32, counter width in bits; legal range 2..64.

Ports:
- clk  input  1  counting clock (ring-oscillator or system clock); all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
- en  input  1  count enable, sampled on the rising edge of clk.
- q  output  SIZE  current count, driven directly from the count register.
- ovf  output  1  sticky wrap flag; set when q wraps from all-ones to zero; may be left unconnected.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (port `reset`).
- Reset:
  - While reset=1: q=0 and ovf=0, regardless of clk and en.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Deassertion is not synchronised internally. The first count can occur on the first rising edge of clk at which reset=0 and en=1.
- Counting:
  - Rising edge of clk with reset=0 and en=1: q <= q + 1, modulo 2^SIZE.
  - Rising edge with en=0: q holds.
  - Latency: q reflects an enabled edge immediately after that edge, i.e. one register stage with no extra pipeline.
- Wrap-around:
  - When q = 2^SIZE-1 and en=1, the next edge gives q=0 and sets ovf=1.
  - ovf stays 1 until reset. There is no saturation.
- Enable toggling: en may change at any time relative to clk. Only its value at the rising edge matters; no glitch filtering is done.
- Reset mid-count: asserting reset while en=1 clears q and ovf at once. Counting resumes from 0 after release.
- No X propagation:
  - q is never X after the first reset assertion.
  - If en is X at an edge, the behaviour is undefined. The bench must not drive X on en.
- Outputs are registered only; there is no combinational path from en to q.
- Arithmetic: unsigned, SIZE bits; the carry out of the MSB is used only to set ovf.

Decomposition:
- Shared package ro_puf_pkg:
  - constant RO_CNT_WIDTH = 32, used for SIZE at instantiation sites.
  - typedef ro_count_t = logic [RO_CNT_WIDTH-1:0].
- No sub-module. The block is a single register plus incrementer and flag logic.
- An optional SVA bind file (ro_edge_counter_sva) holds the assertions:
  - q is stable when en=0.
  - q increments by exactly 1 when en=1.
  - q==0 while reset=1.

Test Plan:
- Reset then count (SIZE=32, 10 ns clk period):
  - Stimulus: reset=1, en=0 for 10 ns; release reset and set en=1 at t=10 ns; hold for 100 ns (10 rising edges); set en=0; wait 20 ns.
  - Required: q=10 at end; q unchanged during the final 20 ns.
- Enable gating: with q=5, hold en=0 for 8 edges → q remains 5; set en=1 for 3 edges → q=8.
- Wrap (SIZE=4):
  - Stimulus: count 15 enabled edges; then 1 more edge.
  - Required: q=15 after the 15 edges; after the 16th edge q=0 and ovf=1; after 2 more edges q=2 and ovf=1.
- Asynchronous reset mid-count:
  - Stimulus: at q=7, pulse reset=1 for 3 ns between clock edges with en=1.
  - Required: q=0 and ovf=0 immediately, before the next edge; after release, the next edge gives q=1.
- Reset dominance: hold reset=1 and en=1 for 5 edges → q stays 0.
- Randomised en toggling over 1000 edges (SIZE=32): final q equals the number of edges sampled with en=1, compared against a reference-model count.
